// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory cache responder.
//   Contents:
//     ADDR_W / DATA_W   request address and data widths
//     ST_* / state_e    responder FSM encoding (IDLE, WB, FILL, RESP, FLUSH)
//     idx_w / tag_w     index and tag field widths for a given line count
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WB    = 3'd1;
   localparam logic [2:0] ST_FILL  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_WB    = ST_WB,
      S_FILL  = ST_FILL,
      S_RESP  = ST_RESP,
      S_FLUSH = ST_FLUSH
   } state_e;

   // Index selects a line from the word address (byte bit 0 excluded).
   function automatic int idx_w(input int lines);
      return $clog2(lines);
   endfunction

   // Tag is whatever is left of the word address above the index.
   function automatic int tag_w(input int lines);
      return ADDR_W - 1 - $clog2(lines);
   endfunction

endpackage

// File: rtl/dmem_backing.sv
// -----------------------------------------------------------------------------
// dmem_backing
//   Fixed-latency backing word memory. One access at a time: a start pulse
//   launches a read or write; ack rises in the MEM_LAT-th cycle counting the
//   start cycle itself, so with MEM_LAT=1 ack coincides with start. Writes
//   commit on the ack edge; rdata is valid while ack is high. Reset aborts
//   an access in flight and its write is dropped. The array is never cleared.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-low reset
//     start_i, we_i     launch an access (ignored while busy), write enable
//     addr_i, wdata_i   word address and write data (captured on launch)
//     busy_o            an access is in flight after its launch cycle
//     ack_o             access completes this cycle
//     rdata_o           read data for the current access
// -----------------------------------------------------------------------------
module dmem_backing #(
   parameter int MEM_AW  = 15,
   parameter int MEM_LAT = 4,
   parameter int DW      = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              we_i,
   input  logic [MEM_AW-1:0] addr_i,
   input  logic [DW-1:0]     wdata_i,
   output logic              busy_o,
   output logic              ack_o,
   output logic [DW-1:0]     rdata_o
);

   localparam int   CW      = $clog2(MEM_LAT + 1);
   localparam logic ONE_CYC = (MEM_LAT == 1);

   logic              busy_q;
   logic [CW-1:0]     cnt_q;
   logic [MEM_AW-1:0] addr_q;
   logic              we_q;
   logic [DW-1:0]     wdata_q;
   logic [DW-1:0]     mem_q [2**MEM_AW];

   logic              launch;
   logic [MEM_AW-1:0] op_addr;
   logic              op_we;
   logic [DW-1:0]     op_wdata;

   assign launch   = rst_i & start_i & ~busy_q;
   // Launch cycle uses the live request; later cycles use the captured copy.
   assign op_addr  = busy_q ? addr_q  : addr_i;
   assign op_we    = busy_q ? we_q    : we_i;
   assign op_wdata = busy_q ? wdata_q : wdata_i;

   // cnt_q holds the cycles still to go including the current one.
   assign ack_o   = rst_i & (busy_q ? (cnt_q == CW'(1)) : (launch & ONE_CYC));
   assign busy_o  = busy_q;
   assign rdata_o = mem_q[op_addr];

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (busy_q) begin
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) busy_q <= 1'b0;
      end else if (launch && !ONE_CYC) begin
         busy_q <= 1'b1;
         cnt_q  <= CW'(MEM_LAT - 1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (launch) begin
         addr_q  <= addr_i;
         we_q    <= we_i;
         wdata_q <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (ack_o && op_we) mem_q[op_addr] <= op_wdata;
   end

endmodule

// File: rtl/dmem_cache_responder.sv
// -----------------------------------------------------------------------------
// dmem_cache_responder
//   Responder for the Memory-stage data request interface. Direct-mapped,
//   write-back, one word per line cache in front of dmem_backing.
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     Addr, DataIn      byte address (bit 0 must be 0), write data
//     Rd, Wr            read / write request
//     createdump        write every dirty line back to the backing memory
//     DataOut           read data (qualified by valid)
//     Done              request complete (one-cycle pulse)
//     Stall             busy; initiator holds its request
//     CacheHit          with Done: served without a backing access
//     valid             DataOut carries read data
//     err               illegal request (Rd&Wr or odd address), ignored
//   The backing access for a miss or for a dirty line during flush is
//   launched in the first cycle that needs it, including the IDLE request
//   cycle, so the visible Stall time equals the backing time exactly.
// -----------------------------------------------------------------------------
module dmem_cache_responder
   import dmem_pkg::*;
#(
   parameter int LINES   = 16,
   parameter int MEM_LAT = 4,
   parameter int MEM_AW  = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit,
   output logic        valid,
   output logic        err
);

   localparam int IW = idx_w(LINES);
   localparam int TW = tag_w(LINES);

   // Cache arrays
   logic [LINES-1:0]  vld_q;
   logic [LINES-1:0]  drt_q;
   logic [TW-1:0]     tag_q [LINES];
   logic [DATA_W-1:0] dat_q [LINES];

   // FSM, flush pointer and request latch
   state_e            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [ADDR_W-1:1] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;

   // Single line-update port
   logic              ln_we;
   logic [IW-1:0]     ln_idx;
   logic [TW-1:0]     ln_tag;
   logic [DATA_W-1:0] ln_data;
   logic              ln_dirty;

   // Backing memory handshake
   logic              mem_start, mem_we, mem_busy, mem_ack;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   // Request view: live inputs in IDLE, latched copy everywhere else
   logic              in_idle;
   logic [ADDR_W-1:1] e_addr;
   logic [IW-1:0]     e_idx;
   logic [TW-1:0]     e_tag;
   logic [DATA_W-1:0] e_din;
   logic              e_wr;
   logic              hit, illegal;
   logic              wb_go, fill_go, flush_go, step;

   assign in_idle = (state_q == S_IDLE);
   assign e_addr  = in_idle ? Addr[ADDR_W-1:1] : addr_q;
   assign e_din   = in_idle ? DataIn : din_q;
   assign e_wr    = in_idle ? Wr : wr_q;
   assign e_idx   = e_addr[IW:1];
   assign e_tag   = e_addr[ADDR_W-1:IW+1];
   assign hit     = vld_q[e_idx] && (tag_q[e_idx] == e_tag);
   assign illegal = (Rd & Wr) | ((Rd | Wr) & Addr[0]);

   dmem_backing #(
      .MEM_AW  (MEM_AW),
      .MEM_LAT (MEM_LAT),
      .DW      (DATA_W)
   ) u_backing (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (mem_start),
      .we_i    (mem_we),
      .addr_i  (mem_addr),
      .wdata_i (mem_wdata),
      .busy_o  (mem_busy),
      .ack_o   (mem_ack),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      din_d     = din_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      ln_we     = 1'b0;
      ln_idx    = '0;
      ln_tag    = '0;
      ln_data   = '0;
      ln_dirty  = 1'b0;
      mem_start = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      DataOut   = '0;
      Done      = 1'b0;
      Stall     = 1'b0;
      CacheHit  = 1'b0;
      valid     = 1'b0;
      err       = 1'b0;
      wb_go     = 1'b0;
      fill_go   = 1'b0;
      flush_go  = 1'b0;
      step      = 1'b0;

      // While reset is low everything stays quiet and nothing is launched.
      if (rst) begin
         unique case (state_q)
            S_IDLE: begin
               if (Rd | Wr) begin
                  if (illegal) begin
                     err = 1'b1;
                  end else if (hit) begin
                     Done     = 1'b1;
                     CacheHit = 1'b1;
                     if (Rd) begin
                        valid   = 1'b1;
                        DataOut = dat_q[e_idx];
                     end else begin
                        ln_we    = 1'b1;
                        ln_idx   = e_idx;
                        ln_tag   = e_tag;
                        ln_data  = DataIn;
                        ln_dirty = 1'b1;
                     end
                  end else begin
                     Stall  = 1'b1;
                     addr_d = Addr[ADDR_W-1:1];
                     din_d  = DataIn;
                     rd_d   = Rd;
                     wr_d   = Wr;
                     if (drt_q[e_idx]) wb_go = 1'b1;
                     else              fill_go = 1'b1;
                  end
               end else if (createdump) begin
                  // Flush ends in RESP with valid low.
                  Stall    = 1'b1;
                  rd_d     = 1'b0;
                  wr_d     = 1'b0;
                  flush_go = 1'b1;
               end
            end
            S_WB: begin
               Stall = 1'b1;
               wb_go = 1'b1;
            end
            S_FILL: begin
               Stall   = 1'b1;
               fill_go = 1'b1;
            end
            S_RESP: begin
               Done    = 1'b1;
               valid   = rd_q;
               DataOut = rd_q ? dat_q[e_idx] : '0;
               state_d = S_IDLE;
            end
            S_FLUSH: begin
               Stall    = 1'b1;
               flush_go = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase

         // Victim write-back, then refill
         if (wb_go) begin
            mem_start = ~mem_busy;
            mem_we    = 1'b1;
            mem_addr  = MEM_AW'({tag_q[e_idx], e_idx});
            mem_wdata = dat_q[e_idx];
            state_d   = mem_ack ? S_FILL : S_WB;
         end

         // Refill; a pending write replaces the whole fetched word.
         if (fill_go) begin
            mem_start = ~mem_busy;
            mem_addr  = MEM_AW'(e_addr);
            state_d   = S_FILL;
            if (mem_ack) begin
               ln_we    = 1'b1;
               ln_idx   = e_idx;
               ln_tag   = e_tag;
               ln_data  = e_wr ? e_din : mem_rdata;
               ln_dirty = e_wr;
               state_d  = S_RESP;
            end
         end

         // Walk every line; ptr_q is zero whenever the FSM sits in IDLE.
         if (flush_go) begin
            state_d = S_FLUSH;
            if (drt_q[ptr_q]) begin
               mem_start = ~mem_busy;
               mem_we    = 1'b1;
               mem_addr  = MEM_AW'({tag_q[ptr_q], ptr_q});
               mem_wdata = dat_q[ptr_q];
               if (mem_ack) begin
                  ln_we    = 1'b1;
                  ln_idx   = ptr_q;
                  ln_tag   = tag_q[ptr_q];
                  ln_data  = dat_q[ptr_q];
                  ln_dirty = 1'b0;
                  step     = 1'b1;
               end
            end else begin
               step = 1'b1;
            end
            if (step) begin
               if (ptr_q == IW'(LINES - 1)) begin
                  ptr_d   = '0;
                  state_d = S_RESP;
               end else begin
                  ptr_d = ptr_q + IW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         vld_q   <= '0;
         drt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         if (ln_we) begin
            vld_q[ln_idx] <= 1'b1;
            drt_q[ln_idx] <= ln_dirty;
         end
      end
   end

   // Payload storage needs no reset; validity is tracked by vld_q.
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      din_q  <= din_d;
      if (ln_we) begin
         tag_q[ln_idx] <= ln_tag;
         dat_q[ln_idx] <= ln_data;
      end
   end

endmodule

// File: tb/tb_dmem_cache_responder.sv
module tb_dmem_cache_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Addr, DataIn, DataOut;
   logic        Rd, Wr, createdump;
   logic        Done, Stall, CacheHit, valid, err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_cache_responder #(.LINES(16), .MEM_LAT(4), .MEM_AW(15)) dut (
      .clk        (clk),
      .rst        (rst),
      .Addr       (Addr),
      .DataIn     (DataIn),
      .Rd         (Rd),
      .Wr         (Wr),
      .createdump (createdump),
      .DataOut    (DataOut),
      .Done       (Done),
      .Stall      (Stall),
      .CacheHit   (CacheHit),
      .valid      (valid),
      .err        (err)
   );

   typedef struct {
      logic        rd, wr, dump;
      logic [15:0] a, d;
      logic        e_stall, e_done, e_hit, e_valid, e_err;
      logic [15:0] e_dout;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic dump,
                        input logic [15:0] a, input logic [15:0] d);
      Rd = rd; Wr = wr; createdump = dump; Addr = a; DataIn = d;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 0, 16'h0, 16'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Hold a request until Done, counting Stall cycles on the way.
   task automatic req(input logic rd, input logic wr, input logic dump,
                      input logic [15:0] a, input logic [15:0] d,
                      output int st, output logic [15:0] dout,
                      output logic vl, output logic hit, output logic got,
                      output logic both);
      drive(rd, wr, dump, a, d);
      st = 0; got = 1'b0; both = 1'b0; dout = '0; vl = 1'b0; hit = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (Done) begin
            got  = 1'b1;
            dout = DataOut;
            vl   = valid;
            hit  = CacheHit;
            both = Stall;
            break;
         end
         if (Stall) st++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      drive(0, 0, 0, 16'h0, 16'h0);
   endtask

   task automatic txn(input string nm, input logic rd, input logic wr, input logic dump,
                      input logic [15:0] a, input logic [15:0] d,
                      input int e_st, input logic e_hit, input logic e_vl,
                      input logic [15:0] e_dout);
      int          st;
      logic [15:0] dout;
      logic        vl, hit, got, both;
      req(rd, wr, dump, a, d, st, dout, vl, hit, got, both);
      chk({nm, " done"}, got, 1);
      chk({nm, " stall cycles"}, st, e_st);
      chk({nm, " stall with done"}, both, 0);
      chk({nm, " hit"}, hit, e_hit);
      chk({nm, " valid"}, vl, e_vl);
      if (e_vl) chk({nm, " data"}, dout, e_dout);
   endtask

   task automatic quiet(input string nm);
      chk({nm, " Stall"}, Stall, 0);
      chk({nm, " Done"}, Done, 0);
      chk({nm, " CacheHit"}, CacheHit, 0);
      chk({nm, " valid"}, valid, 0);
      chk({nm, " err"}, err, 0);
   endtask

   initial begin
      //            rd wr dp  addr      din       stl dn hit vld err dout
      tbl[0] = '{1, 0, 0, 16'h0010, 16'h0000, 0, 1, 1, 1, 0, 16'h1234};
      tbl[1] = '{1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 1, 16'h0000};
      tbl[2] = '{1, 0, 0, 16'h0011, 16'h0000, 0, 0, 0, 0, 1, 16'h0000};
      tbl[3] = '{0, 1, 0, 16'h0011, 16'hDEAD, 0, 0, 0, 0, 1, 16'h0000};
      tbl[4] = '{1, 0, 0, 16'h0010, 16'h0000, 0, 1, 1, 1, 0, 16'h1234};
      tbl[5] = '{0, 1, 0, 16'h0010, 16'hBEEF, 0, 1, 1, 0, 0, 16'h0000};
      tbl[6] = '{1, 0, 1, 16'h0010, 16'h0000, 0, 1, 1, 1, 0, 16'hBEEF};
      tbl[7] = '{1, 0, 0, 16'h0010, 16'h0000, 0, 1, 1, 1, 0, 16'hBEEF};

      // Reset: outputs stay low even with a request asserted.
      rst = 1'b0;
      drive(1, 0, 0, 16'h0010, 16'h0);
      @(negedge clk);
      quiet("in reset");
      do_reset();
      @(negedge clk);
      quiet("after reset");
      @(posedge clk); #1;

      // Seed backing words 8 and 0x18 through the cache itself.
      txn("seed wr miss",     0, 1, 0, 16'h0010, 16'h1234, 4, 0, 0, 16'h0);
      txn("seed wr dirty",    0, 1, 0, 16'h0030, 16'h5A5A, 8, 0, 0, 16'h0);
      txn("seed dump",        0, 0, 1, 16'h0000, 16'h0000, 19, 0, 0, 16'h0);
      do_reset();

      // 1: clean read miss
      txn("t1 rd miss",       1, 0, 0, 16'h0010, 16'h0000, 4, 0, 1, 16'h1234);

      // 2/4: single-cycle hits and illegal requests
      foreach (tbl[i]) begin
         drive(tbl[i].rd, tbl[i].wr, tbl[i].dump, tbl[i].a, tbl[i].d);
         @(negedge clk);
         chk($sformatf("vec%0d Stall", i), Stall, tbl[i].e_stall);
         chk($sformatf("vec%0d Done", i), Done, tbl[i].e_done);
         chk($sformatf("vec%0d CacheHit", i), CacheHit, tbl[i].e_hit);
         chk($sformatf("vec%0d valid", i), valid, tbl[i].e_valid);
         chk($sformatf("vec%0d err", i), err, tbl[i].e_err);
         if (tbl[i].e_valid) chk($sformatf("vec%0d DataOut", i), DataOut, tbl[i].e_dout);
         @(posedge clk); #1;
      end
      drive(0, 0, 0, 16'h0, 16'h0);

      // 3: dirty victim, then confirm the write-back landed
      txn("t3 rd dirty victim", 1, 0, 0, 16'h0030, 16'h0000, 8, 0, 1, 16'h5A5A);
      txn("t3 wb readback",     1, 0, 0, 16'h0010, 16'h0000, 4, 0, 1, 16'hBEEF);

      // 5: two dirty lines then dump; a second dump finds nothing dirty
      txn("t5 wr hit",        0, 1, 0, 16'h0010, 16'h1111, 0, 1, 0, 16'h0);
      txn("t5 wr miss",       0, 1, 0, 16'h0002, 16'h2222, 4, 0, 0, 16'h0);
      txn("t5 dump",          0, 0, 1, 16'h0000, 16'h0000, 22, 0, 0, 16'h0);
      txn("t5 dump clean",    0, 0, 1, 16'h0000, 16'h0000, 16, 0, 0, 16'h0);
      do_reset();
      txn("t5 read line8",    1, 0, 0, 16'h0010, 16'h0000, 4, 0, 1, 16'h1111);
      txn("t5 read line1",    1, 0, 0, 16'h0002, 16'h0000, 4, 0, 1, 16'h2222);

      // 6: reset in the middle of a write-back
      txn("t6 wr hit",        0, 1, 0, 16'h0010, 16'h7777, 0, 1, 0, 16'h0);
      drive(1, 0, 0, 16'h0030, 16'h0);
      @(negedge clk);
      chk("t6 req Stall", Stall, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6 wb Stall", Stall, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 0, 0, 16'h0, 16'h0);
      @(negedge clk);
      quiet("t6 in reset");
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      quiet("t6 after reset");
      chk("t6 after reset DataOut", DataOut, 16'h0);
      @(posedge clk); #1;
      txn("t6 no wb",         1, 0, 0, 16'h0010, 16'h0000, 4, 0, 1, 16'h1111);
      txn("t6 other tag",     1, 0, 0, 16'h0030, 16'h0000, 4, 0, 1, 16'h5A5A);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
